// File: rtl/mvm_stream_source_if.sv
// Valid/ready stream bundle feeding the MAC datapath input.
// The source drives data/valid/last and the sink returns ready.
interface mvm_stream_source_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] s_data;
   logic             s_valid;
   logic             s_last;
   logic             s_ready;

   modport master (
      output s_data,
      output s_valid,
      output s_last,
      input  s_ready
   );

   modport slave (
      input  s_data,
      input  s_valid,
      input  s_last,
      output s_ready
   );
endinterface

// File: rtl/mvm_stream_source.sv
// Host-loaded M/X word buffer streamed out as one valid/ready burst
// (M words first, then X), with s_last marking the final word.
module mvm_stream_source #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned SIZE_M  = 9,
   parameter int unsigned SIZE_X  = 3,
   parameter int unsigned LOGSIZE = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   host_wr_en,
   input  logic [LOGSIZE-1:0]     host_addr,
   input  logic [WIDTH-1:0]       host_wr_data,
   input  logic                   start,
   mvm_stream_source_if.master    s,
   output logic                   busy,
   output logic                   done,
   output logic                   wr_err
);

   localparam int unsigned        TOTAL    = SIZE_M + SIZE_X;
   localparam int unsigned        DEPTH    = 2 ** LOGSIZE;
   localparam logic [LOGSIZE-1:0] LAST_IDX = LOGSIZE'(TOTAL - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      FIN
   } state_t;

   state_t             state_q, state_d;
   logic [LOGSIZE-1:0] index_q, index_d;
   logic [LOGSIZE-1:0] index_nxt;
   logic [WIDTH-1:0]   s_data_q, s_data_d;
   logic               s_valid_q, s_valid_d;
   logic               s_last_q, s_last_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               wr_err_q, wr_err_d;

   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic               addr_ok;
   logic               mem_we;
   logic               beat;

   assign addr_ok   = (32'(host_addr) < TOTAL);
   assign beat      = s_valid_q && s.s_ready;
   assign index_nxt = index_q + LOGSIZE'(1);

   // start takes priority over a same-cycle host write, so the stream
   // always launches from the buffer contents as they were before that edge.
   assign mem_we = host_wr_en && (state_q == IDLE) && !start && addr_ok && !reset;

   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      s_data_d  = s_data_q;
      s_valid_d = s_valid_q;
      s_last_d  = s_last_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      wr_err_d  = host_wr_en && !mem_we;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SEND;
               index_d   = '0;
               s_data_d  = mem_q[0];
               s_valid_d = 1'b1;
               s_last_d  = (TOTAL == 1);
               busy_d    = 1'b1;
            end
         end

         SEND: begin
            if (beat) begin
               if (index_q == LAST_IDX) begin
                  state_d   = FIN;
                  s_valid_d = 1'b0;
                  s_last_d  = 1'b0;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
               end else begin
                  // Next word is fetched on the accepting edge: no bubble.
                  index_d  = index_nxt;
                  s_data_d = mem_q[index_nxt];
                  s_last_d = (index_nxt == LAST_IDX);
               end
            end
         end

         FIN: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         index_q   <= '0;
         s_data_q  <= '0;
         s_valid_q <= 1'b0;
         s_last_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         s_data_q  <= s_data_d;
         s_valid_q <= s_valid_d;
         s_last_q  <= s_last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wr_err_q  <= wr_err_d;
      end
   end

   // Buffer contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[host_addr] <= host_wr_data;
      end
   end

   assign s.s_data  = s_data_q;
   assign s.s_valid = s_valid_q;
   assign s.s_last  = s_last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign wr_err    = wr_err_q;

   a_stall_stable: assert property (@(posedge clk) disable iff (reset)
      (s_valid_q && !s.s_ready) |=> (s_valid_q && $stable(s_data_q) && $stable(s_last_q)));

   a_index_range: assert property (@(posedge clk) disable iff (reset)
      (index_q <= LAST_IDX));

   a_last_only_final: assert property (@(posedge clk) disable iff (reset)
      s_last_q |-> (s_valid_q && (index_q == LAST_IDX)));

endmodule

// File: tb/tb_mvm_stream_source.sv
// Directed bench for mvm_stream_source: host loads, full-rate and stalled
// streams, dropped writes, start/write collision and mid-transfer reset.
module tb_mvm_stream_source;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned SIZE_M  = 9;
   localparam int unsigned SIZE_X  = 3;
   localparam int unsigned LOGSIZE = 4;
   localparam int unsigned TOTAL   = SIZE_M + SIZE_X;
   localparam int          BOUND   = 200;

   logic               clk;
   logic               reset;
   logic               host_wr_en;
   logic [LOGSIZE-1:0] host_addr;
   logic [WIDTH-1:0]   host_wr_data;
   logic               start;
   logic               busy;
   logic               done;
   logic               wr_err;

   logic [WIDTH-1:0]   exp_buf [16];
   int                 n_checks;
   int                 n_pass;

   mvm_stream_source_if #(.WIDTH(WIDTH)) s_if ();

   mvm_stream_source #(
      .WIDTH   (WIDTH),
      .SIZE_M  (SIZE_M),
      .SIZE_X  (SIZE_X),
      .LOGSIZE (LOGSIZE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .host_wr_en   (host_wr_en),
      .host_addr    (host_addr),
      .host_wr_data (host_wr_data),
      .start        (start),
      .s            (s_if),
      .busy         (busy),
      .done         (done),
      .wr_err       (wr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [LOGSIZE-1:0] addr, input logic [WIDTH-1:0] data,
                             input bit expect_err);
      host_wr_en   = 1'b1;
      host_addr    = addr;
      host_wr_data = data;
      tick();
      host_wr_en   = 1'b0;
      check("wr_err_after_write", 32'(wr_err), 32'(expect_err));
      if (!expect_err) exp_buf[addr] = data;
   endtask

   // rpat: s_ready per cycle, bit k used on cycle k mod 4.
   // wr_at: cycle (counted from the first valid cycle) carrying a write to addr 3.
   task automatic run_stream(input logic [3:0] rpat, input int wr_at, input bit wr_with_start);
      int e;
      int c;
      logic ready_now;
      start     = 1'b1;
      s_if.s_ready = 1'b0;
      if (wr_with_start) begin
         host_wr_en   = 1'b1;
         host_addr    = '0;
         host_wr_data = 8'h55;
      end
      tick();
      start      = 1'b0;
      host_wr_en = 1'b0;
      check("wr_err_on_start", 32'(wr_err), 32'(wr_with_start));

      e = 0;
      c = 0;
      while (e < int'(TOTAL) && c < BOUND) begin
         ready_now    = rpat[2'(c)];
         s_if.s_ready = ready_now;
         host_wr_en   = (c == wr_at);
         host_addr    = 4'd3;
         host_wr_data = 8'hAA;
         check("s_valid", 32'(s_if.s_valid), 32'd1);
         check("busy", 32'(busy), 32'd1);
         check("done_early", 32'(done), 32'd0);
         check("s_data", 32'(s_if.s_data), 32'(exp_buf[e]));
         check("s_last", 32'(s_if.s_last), 32'(e == int'(TOTAL) - 1));
         if (ready_now) e++;
         tick();
         check("wr_err_stream", 32'(wr_err), 32'(c == wr_at));
         c++;
      end
      host_wr_en   = 1'b0;
      s_if.s_ready = 1'b0;
      check("beats_delivered", 32'(e), 32'(TOTAL));
      if (rpat == 4'hF) check("full_rate_cycles", 32'(c), 32'(TOTAL));
      check("end_s_valid", 32'(s_if.s_valid), 32'd0);
      check("end_s_last", 32'(s_if.s_last), 32'd0);
      check("end_busy", 32'(busy), 32'd0);
      check("done_pulse", 32'(done), 32'd1);

      // start while in FIN must be ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      check("done_clears", 32'(done), 32'd0);
      check("fin_start_ignored_valid", 32'(s_if.s_valid), 32'd0);
      check("fin_start_ignored_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      n_checks     = 0;
      n_pass       = 0;
      reset        = 1'b1;
      host_wr_en   = 1'b0;
      host_addr    = '0;
      host_wr_data = '0;
      start        = 1'b0;
      s_if.s_ready = 1'b0;
      tick();
      tick();
      check("rst_s_valid", 32'(s_if.s_valid), 32'd0);
      check("rst_s_last", 32'(s_if.s_last), 32'd0);
      check("rst_s_data", 32'(s_if.s_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wr_err", 32'(wr_err), 32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < int'(TOTAL); i++) host_write(4'(i), 8'(i + 1), 1'b0);

      // Full-rate stream 1..12
      run_stream(4'hF, -1, 1'b0);

      // Stalled stream: ready pattern 1,0,0,1 (back-to-back start after done)
      run_stream(4'b1001, -1, 1'b0);

      // Write during SEND dropped; word 3 stays 4 now and next time
      run_stream(4'hF, 3, 1'b0);
      run_stream(4'hF, -1, 1'b0);

      // start wins over simultaneous write to addr 0
      run_stream(4'hF, -1, 1'b1);

      // Reset after 5 beats aborts with no done pulse
      start        = 1'b1;
      tick();
      start        = 1'b0;
      s_if.s_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("pre_reset_data", 32'(s_if.s_data), 32'(k + 1));
         tick();
      end
      check("pre_reset_word6", 32'(s_if.s_data), 32'd6);
      reset = 1'b1;
      tick();
      reset        = 1'b0;
      s_if.s_ready = 1'b0;
      check("abort_s_valid", 32'(s_if.s_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_s_data", 32'(s_if.s_data), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("abort_no_done", 32'(done), 32'd0);
         check("abort_idle_valid", 32'(s_if.s_valid), 32'd0);
      end
      run_stream(4'hF, -1, 1'b0);

      // Out-of-range writes dropped; stream unchanged
      host_write(4'd12, 8'hEE, 1'b1);
      tick();
      check("wr_err_one_cycle", 32'(wr_err), 32'd0);
      host_write(4'd15, 8'hDD, 1'b1);
      run_stream(4'hF, -1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/mvm_stream_source.md
Name: mvm_stream_source

Overview:
- Transmit-side counterpart of the matrix-vector MAC datapath's input stream.
- A host preloads matrix M (SIZE_M words, row-major) and vector X (SIZE_X words) into an internal buffer.
- On start, the block streams all words on a valid/ready interface: M first, then X, with one s_last marker on the final word.
- Sits between the host/testbench and the MAC datapath's data_in/s_valid input.

Parameters:
- WIDTH, 8, data word width.
- SIZE_M, 9, number of matrix words.
- SIZE_X, 3, number of vector words.
- LOGSIZE, 4, buffer address width; must satisfy 2**LOGSIZE >= SIZE_M+SIZE_X.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- host_wr_en  input  1  host buffer write strobe.
- host_addr  input  LOGSIZE  buffer word address; 0..SIZE_M-1 = M, SIZE_M..SIZE_M+SIZE_X-1 = X.
- host_wr_data  input  WIDTH  word to write.
- start  input  1  begin a transfer (sampled in IDLE only).
- s_data  output  WIDTH  stream data to MAC datapath.
- s_valid  output  1  s_data valid.
- s_last  output  1  high with the final word (index SIZE_M+SIZE_X-1).
- s_ready  input  1  sink accepts current word.
- busy  output  1  high from the cycle after start until the last beat is accepted.
- done  output  1  one-cycle pulse after the last beat.
- wr_err  output  1  one-cycle pulse when a host write is dropped.

Behaviour:
- Reset: clk; reset is synchronous, active-high.
  - Outputs after reset: s_valid=0, s_last=0, s_data=0, busy=0, done=0, wr_err=0, FSM=IDLE, index=0.
  - Buffer contents are not reset.
  - Reset mid-transfer aborts immediately; no done pulse.
- Beat: a transfer occurs on a rising edge where s_valid=1 and s_ready=1.
- FSM states: IDLE, SEND, FIN.
  - IDLE: host writes accepted.
    - Writes with host_addr >= SIZE_M+SIZE_X are dropped and pulse wr_err next cycle.
    - start=1 -> SEND. On the same edge: s_valid<=1, s_data<=buf[0], index<=0, busy<=1, s_last<=(TOTAL==1).
  - SEND: on each beat, index increments and the next word loads on that edge (no bubble cycles).
    - s_last<=1 when the new index is TOTAL-1.
    - Beat with index TOTAL-1 -> FIN; s_valid<=0, s_last<=0, busy<=0, done<=1.
  - FIN: done returns to 0 -> IDLE. A start in FIN is ignored.
- Stream stability: while s_valid=1 and s_ready=0, s_data and s_last hold stable. s_valid never drops before acceptance.
- Sustained throughput: with s_ready held high, one word per cycle. TOTAL words take TOTAL cycles after the start edge.
- Host write while busy (SEND or FIN): dropped; wr_err pulses the next cycle; the buffer is unchanged.
- start and host_wr_en in the same IDLE cycle: start wins. The write is dropped with a wr_err pulse, and streaming uses the old buffer content.
- start asserted in SEND or FIN: ignored, with no queuing.
- Back-to-back transfers: start may be asserted the cycle after done. The buffer is retained, so an identical stream is resent.
- s_ready asserted while s_valid=0: no effect.
- Widths: s_data is an exact copy of the buffer word. No arithmetic on data. index is a LOGSIZE-bit counter that never exceeds TOTAL-1.

Test Plan:
- Write buf[0..11]=1..12, pulse start, hold s_ready=1 -> s_data 1..12 on 12 consecutive cycles; s_last only with 12; done pulses once the cycle after; busy high exactly 12 cycles.
- Same buffer, s_ready toggling 1,0,0,1,... -> every word delivered once, in order; s_data/s_last stable during stalls; no duplicates or skips.
- host_wr_en to addr 3 (data 0xAA) during SEND -> wr_err pulses; the current and next streams still send the old value 4 at word 3.
- start with simultaneous host write to addr 0 (0x55) -> first word is 1 (old); wr_err=1 next cycle.
- Assert reset after 5 beats -> next cycle s_valid=0, busy=0, done never pulses; a new start resends from word 0 (value 1).
- Write to addr 12 and 15 in IDLE -> wr_err pulses each time; the subsequent stream is unchanged at 1..12.
